// File: rtl/effect_stream_ctrl.sv
// effect_stream_ctrl
// Frames codec samples into a channel-tagged FIFO stream for an external
// effect chain and rebuilds aligned L/R output words from the processed
// stream on each audio sample strobe.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   i_sample_valid      one-cycle audio frame strobe
//   i_l_data/i_r_data   signed codec samples (R ignored when mono)
//   i_mode              0 effect, 1 bypass, 2/3 mute (sampled at the strobe)
//   i_clear_flags       clears the sticky flags (a same-cycle set wins)
//   o_l_data/o_r_data   registered signed outputs
//   o_out_valid         one-cycle pulse when the outputs update
//   o_data_to_eff       input FIFO head word (first-word fall-through)
//   o_eff_channel       tag of the head word (0 = L, 1 = R)
//   o_data_valid        input FIFO not empty
//   i_read_enable       pops the input FIFO head (ignored while empty)
//   i_data_from_eff     processed word from the chain
//   i_eff_channel       tag of the processed word
//   i_dv_from_eff       write strobe for the processed word
//   o_in_fill/o_out_fill  FIFO word counts
//   o_overflow          sticky: a frame or a processed word was dropped
//   o_underflow         sticky: output frame unavailable or misaligned
module effect_stream_ctrl #(
    parameter int d_width        = 24,
    parameter int memory_d_width = 16,
    parameter int address_width  = 4,
    parameter int ram_depth      = 16,
    parameter int channels       = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_sample_valid,
    input  logic [d_width-1:0]        i_l_data,
    input  logic [d_width-1:0]        i_r_data,
    input  logic [1:0]                i_mode,
    input  logic                      i_clear_flags,
    output logic [d_width-1:0]        o_l_data,
    output logic [d_width-1:0]        o_r_data,
    output logic                      o_out_valid,
    output logic [memory_d_width-1:0] o_data_to_eff,
    output logic                      o_eff_channel,
    output logic                      o_data_valid,
    input  logic                      i_read_enable,
    input  logic [memory_d_width-1:0] i_data_from_eff,
    input  logic                      i_eff_channel,
    input  logic                      i_dv_from_eff,
    output logic [address_width:0]    o_in_fill,
    output logic [address_width:0]    o_out_fill,
    output logic                      o_overflow,
    output logic                      o_underflow
);

    localparam int mw = memory_d_width;
    localparam int fw = address_width + 1;
    localparam logic [fw-1:0] depth_c = fw'(ram_depth);
    localparam logic [fw-1:0] chan_c  = fw'(channels);
    localparam logic [1:0]    mode_effect = 2'd0;
    localparam logic [1:0]    mode_bypass = 2'd1;

    // Stream word goes to the MSBs, low bits zero, so the sign is preserved.
    function automatic logic [d_width-1:0] widen(input logic [mw-1:0] w);
        widen = d_width'(w) << (d_width - mw);
    endfunction

    // ---------------- FIFOs (word plus tag in bit mw) ----------------
    logic [mw:0]              in_mem  [ram_depth];
    logic [mw:0]              out_mem [ram_depth];
    logic [address_width-1:0] in_wr_ptr, in_rd_ptr, out_wr_ptr, out_rd_ptr;
    logic [fw-1:0]            in_count, out_count;
    logic                     in_push, in_pop, out_push, out_pop, out_drop;
    logic [mw:0]              in_word, in_head, out_head;
    logic                     out_empty;

    assign in_head       = in_mem[in_rd_ptr];
    assign out_head      = out_mem[out_rd_ptr];
    assign out_empty     = (out_count == fw'(0));
    assign o_data_valid  = (in_count != fw'(0));
    assign o_data_to_eff = o_data_valid ? in_head[mw-1:0] : {mw{1'b0}};
    assign o_eff_channel = o_data_valid ? in_head[mw] : 1'b0;
    assign in_pop        = i_read_enable && o_data_valid;
    assign out_push      = i_dv_from_eff && (out_count != depth_c);
    assign out_drop      = i_dv_from_eff && (out_count == depth_c);
    assign o_in_fill     = in_count;
    assign o_out_fill    = out_count;

    // FIFO storage writes; the arrays themselves need no reset.
    always_ff @(posedge clk) begin
        if (in_push)  in_mem[in_wr_ptr]   <= in_word;
        if (out_push) out_mem[out_wr_ptr] <= {i_eff_channel, i_data_from_eff};
    end

    // FIFO pointers and counts; a simultaneous push and pop leaves a count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_wr_ptr  <= '0;
            in_rd_ptr  <= '0;
            in_count   <= '0;
            out_wr_ptr <= '0;
            out_rd_ptr <= '0;
            out_count  <= '0;
        end else begin
            if (in_push)  in_wr_ptr  <= in_wr_ptr  + address_width'(1);
            if (in_pop)   in_rd_ptr  <= in_rd_ptr  + address_width'(1);
            if (out_push) out_wr_ptr <= out_wr_ptr + address_width'(1);
            if (out_pop)  out_rd_ptr <= out_rd_ptr + address_width'(1);
            if (in_push && !in_pop)       in_count <= in_count + fw'(1);
            else if (!in_push && in_pop)  in_count <= in_count - fw'(1);
            if (out_push && !out_pop)      out_count <= out_count + fw'(1);
            else if (!out_push && out_pop) out_count <= out_count - fw'(1);
        end
    end

    // ---------------- Input framer ----------------
    // L is written in the strobe cycle straight from the input pins; only
    // the R push needs its own state, fed from the latched sample.
    typedef enum logic [1:0] {F_IDLE = 2'd0, F_PUSH_L = 2'd1, F_PUSH_R = 2'd2} framer_t;
    framer_t         f_state, f_next;
    logic [mw-1:0]   r_hold;
    logic            frame_drop;

    // Framer state register and right-sample latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            f_state <= F_IDLE;
            r_hold  <= '0;
        end else begin
            f_state <= f_next;
            if (i_sample_valid) r_hold <= i_r_data[d_width-1 -: mw];
        end
    end

    // Framer next state: admit a frame only when it fits as a whole.
    always_comb begin
        f_next     = f_state;
        in_push    = 1'b0;
        in_word    = '0;
        frame_drop = 1'b0;
        case (f_state)
            F_IDLE: begin
                if (i_sample_valid && ((depth_c - in_count) >= chan_c)) begin
                    in_push = 1'b1;
                    in_word = {1'b0, i_l_data[d_width-1 -: mw]};
                    f_next  = (channels == 2) ? F_PUSH_R : F_IDLE;
                end else if (i_sample_valid) begin
                    frame_drop = 1'b1;
                end else begin
                    f_next = F_IDLE;
                end
            end
            F_PUSH_R: begin
                in_push = 1'b1;
                in_word = {1'b1, r_hold};
                f_next  = F_IDLE;
            end
            default: f_next = F_IDLE;
        endcase
    end

    // ---------------- Output assembler ----------------
    // Outputs are loaded on the edge entering UPDATE, so UPDATE is the
    // cycle in which o_out_valid is high. In bypass/mute the outputs are
    // loaded at the strobe edge and POP_L/POP_R only drain the stream.
    typedef enum logic [1:0] {A_IDLE, A_POP_L, A_POP_R, A_UPDATE} asm_t;
    asm_t                a_state, a_next;
    logic                drain_r, drain_next;
    logic [mw-1:0]       l_word_r, l_word_next;
    logic [d_width-1:0]  l_next, r_next;
    logic                valid_next, under_set;

    // Assembler state, captured L word and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_state     <= A_IDLE;
            drain_r     <= 1'b0;
            l_word_r    <= '0;
            o_l_data    <= '0;
            o_r_data    <= '0;
            o_out_valid <= 1'b0;
        end else begin
            a_state     <= a_next;
            drain_r     <= drain_next;
            l_word_r    <= l_word_next;
            o_l_data    <= l_next;
            o_r_data    <= r_next;
            o_out_valid <= valid_next;
        end
    end

    // Assembler next state; mode is only looked at on the strobe.
    always_comb begin
        a_next      = a_state;
        drain_next  = drain_r;
        l_word_next = l_word_r;
        l_next      = o_l_data;
        r_next      = o_r_data;
        valid_next  = 1'b0;
        out_pop     = 1'b0;
        under_set   = 1'b0;
        case (a_state)
            A_IDLE: begin
                if (i_sample_valid && (i_mode == mode_effect)) begin
                    drain_next = 1'b0;
                    if (!out_empty && out_head[mw]) begin
                        // Misaligned head: drop one word per strobe to resync.
                        out_pop   = 1'b1;
                        under_set = 1'b1;
                    end else if (out_count < chan_c) begin
                        under_set = 1'b1;
                    end else begin
                        a_next = A_POP_L;
                    end
                end else if (i_sample_valid) begin
                    drain_next = 1'b1;
                    valid_next = 1'b1;
                    if (i_mode == mode_bypass) begin
                        l_next = i_l_data;
                        r_next = (channels == 2) ? i_r_data : i_l_data;
                    end else begin
                        l_next = '0;
                        r_next = '0;
                    end
                    a_next = out_empty ? A_IDLE : A_POP_L;
                end else begin
                    a_next = A_IDLE;
                end
            end
            A_POP_L: begin
                out_pop     = !out_empty;
                l_word_next = out_head[mw-1:0];
                if (channels == 2) begin
                    a_next = A_POP_R;
                end else if (drain_r) begin
                    a_next = A_IDLE;
                end else begin
                    l_next     = widen(out_head[mw-1:0]);
                    r_next     = widen(out_head[mw-1:0]);
                    valid_next = 1'b1;
                    a_next     = A_UPDATE;
                end
            end
            A_POP_R: begin
                out_pop = !out_empty;
                if (drain_r) begin
                    a_next = A_IDLE;
                end else begin
                    l_next     = widen(l_word_r);
                    r_next     = widen(out_head[mw-1:0]);
                    valid_next = 1'b1;
                    a_next     = A_UPDATE;
                end
            end
            A_UPDATE: a_next = A_IDLE;
            default:  a_next = A_IDLE;
        endcase
    end

    // Sticky flags; a set event in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (frame_drop || out_drop) o_overflow <= 1'b1;
            else if (i_clear_flags)     o_overflow <= 1'b0;
            if (under_set)              o_underflow <= 1'b1;
            else if (i_clear_flags)     o_underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_effect_stream_ctrl.sv
module tb_effect_stream_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_sample_valid = 1'b0;
    logic [23:0] i_l_data = '0, i_r_data = '0;
    logic [1:0]  i_mode = 2'd0;
    logic        i_clear_flags = 1'b0;
    logic [23:0] o_l_data, o_r_data;
    logic        o_out_valid;
    logic [15:0] o_data_to_eff;
    logic        o_eff_channel, o_data_valid;
    logic        i_read_enable, i_eff_channel, i_dv_from_eff;
    logic [15:0] i_data_from_eff;
    logic [4:0]  o_in_fill, o_out_fill;
    logic        o_overflow, o_underflow;

    // Effect chain model: echo every head word straight back when enabled,
    // otherwise the manual injection signals drive the effect side.
    logic        echo_en = 1'b0, man_re = 1'b0, man_dv = 1'b0, man_tag = 1'b0;
    logic [15:0] man_word = '0;
    assign i_read_enable   = echo_en ? o_data_valid  : man_re;
    assign i_dv_from_eff   = echo_en ? o_data_valid  : man_dv;
    assign i_data_from_eff = echo_en ? o_data_to_eff : man_word;
    assign i_eff_channel   = echo_en ? o_eff_channel : man_tag;

    effect_stream_ctrl dut (
        .clk(clk), .reset(reset), .i_sample_valid(i_sample_valid),
        .i_l_data(i_l_data), .i_r_data(i_r_data), .i_mode(i_mode),
        .i_clear_flags(i_clear_flags), .o_l_data(o_l_data), .o_r_data(o_r_data),
        .o_out_valid(o_out_valid), .o_data_to_eff(o_data_to_eff),
        .o_eff_channel(o_eff_channel), .o_data_valid(o_data_valid),
        .i_read_enable(i_read_enable), .i_data_from_eff(i_data_from_eff),
        .i_eff_channel(i_eff_channel), .i_dv_from_eff(i_dv_from_eff),
        .o_in_fill(o_in_fill), .o_out_fill(o_out_fill),
        .o_overflow(o_overflow), .o_underflow(o_underflow)
    );

    // Mono instance with a permanent echo loop.
    logic        m_sv = 1'b0;
    logic [23:0] m_l, m_r;
    logic        m_valid, m_ch, m_dvalid, m_ovf, m_uf;
    logic [15:0] m_to_eff;
    logic [4:0]  m_in_fill, m_out_fill;

    effect_stream_ctrl #(.channels(1)) dut_m (
        .clk(clk), .reset(reset), .i_sample_valid(m_sv),
        .i_l_data(i_l_data), .i_r_data(i_r_data), .i_mode(i_mode),
        .i_clear_flags(i_clear_flags), .o_l_data(m_l), .o_r_data(m_r),
        .o_out_valid(m_valid), .o_data_to_eff(m_to_eff),
        .o_eff_channel(m_ch), .o_data_valid(m_dvalid),
        .i_read_enable(m_dvalid), .i_data_from_eff(m_to_eff),
        .i_eff_channel(m_ch), .i_dv_from_eff(m_dvalid),
        .o_in_fill(m_in_fill), .o_out_fill(m_out_fill),
        .o_overflow(m_ovf), .o_underflow(m_uf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard of expected output updates for the stereo instance.
    typedef struct {
        int          at;
        logic [23:0] l;
        logic [23:0] r;
    } exp_t;
    exp_t sb[$];

    // Every o_out_valid pulse must match the oldest expectation, including its cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && o_out_valid) begin
            if (sb.size() == 0) begin
                check("sb_spurious_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_latency", cyc, e.at);
                check("sb_l", o_l_data, e.l);
                check("sb_r", o_r_data, e.r);
            end
        end
    end

    function automatic logic [23:0] trunc(input logic [23:0] s);
        trunc = {s[23:8], 8'h00};
    endfunction

    // Stereo strobe; the next strobe may come six cycles later.
    task automatic strobe(input logic [1:0] mode, input logic [23:0] l, input logic [23:0] r,
                          input bit expv, input int lat, input logic [23:0] el,
                          input logic [23:0] er, input bit clr);
        exp_t e;
        i_mode = mode; i_l_data = l; i_r_data = r;
        i_sample_valid = 1'b1; i_clear_flags = clr;
        if (expv) begin
            e.at = cyc + lat; e.l = el; e.r = er;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        i_sample_valid = 1'b0; i_clear_flags = 1'b0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic mono_strobe(input logic [1:0] mode, input logic [23:0] l);
        i_mode = mode; i_l_data = l; i_r_data = 24'h0F0F0F; m_sv = 1'b1;
        @(posedge clk); #1;
        m_sv = 1'b0;
    endtask

    task automatic clear_flags();
        i_clear_flags = 1'b1;
        @(posedge clk); #1;
        i_clear_flags = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [23:0] pl, pr, nl, nr;
        do_reset();

        // Reset state
        check("rst_l", o_l_data, 24'h0);
        check("rst_r", o_r_data, 24'h0);
        check("rst_valid", o_out_valid, 1'b0);
        check("rst_dv", o_data_valid, 1'b0);
        check("rst_head", o_data_to_eff, 16'h0);
        check("rst_in_fill", o_in_fill, 5'd0);
        check("rst_out_fill", o_out_fill, 5'd0);
        check("rst_flags", {o_overflow, o_underflow}, 2'b00);

        // Stereo loopback: first strobe finds the output stream empty
        echo_en = 1'b1;
        strobe(2'd0, 24'h123456, 24'hFEDCBA, 1'b0, 0, 24'h0, 24'h0, 1'b0);
        check("loop_first_uf", o_underflow, 1'b1);
        check("loop_out_fill", o_out_fill, 5'd2);
        check("loop_in_fill", o_in_fill, 5'd0);
        clear_flags();
        check("loop_uf_clear", o_underflow, 1'b0);
        strobe(2'd0, 24'h123456, 24'hFEDCBA, 1'b1, 3, 24'h123400, 24'hFEDC00, 1'b0);
        check("loop_flags", {o_overflow, o_underflow}, 2'b00);
        pl = 24'h123456; pr = 24'hFEDCBA;
        for (int i = 0; i < 3; i++) begin
            nl = 24'($urandom); nr = 24'($urandom);
            strobe(2'd0, nl, nr, 1'b1, 3, trunc(pl), trunc(pr), 1'b0);
            pl = nl; pr = nr;
        end

        // Underflow: chain stops returning data
        echo_en = 1'b0;
        strobe(2'd0, 24'h0A0B0C, 24'h0D0E0F, 1'b1, 3, trunc(pl), trunc(pr), 1'b0);
        strobe(2'd0, 24'h111111, 24'h222222, 1'b0, 0, 24'h0, 24'h0, 1'b0);
        check("uf_flag", o_underflow, 1'b1);
        check("uf_hold_l", o_l_data, trunc(pl));
        check("uf_hold_r", o_r_data, trunc(pr));
        check("uf_out_fill", o_out_fill, 5'd0);
        check("uf_in_fill", o_in_fill, 5'd4);

        // Overflow with the chain not reading; bypass outputs at strobe + 1
        do_reset();
        check("ovf_rst_fill", o_in_fill, 5'd0);
        strobe(2'd1, 24'h7FFFFF, 24'h800000, 1'b1, 1, 24'h7FFFFF, 24'h800000, 1'b0);
        for (int i = 1; i < 8; i++) begin
            nl = 24'($urandom); nr = 24'($urandom);
            strobe(2'd1, nl, nr, 1'b1, 1, nl, nr, 1'b0);
        end
        check("ovf_fill_16", o_in_fill, 5'd16);
        check("ovf_not_yet", o_overflow, 1'b0);
        check("ovf_head", o_data_to_eff, 16'h7FFF);
        check("ovf_head_tag", o_eff_channel, 1'b0);
        strobe(2'd2, 24'h333333, 24'h444444, 1'b1, 1, 24'h0, 24'h0, 1'b0);
        check("ovf_fill_kept", o_in_fill, 5'd16);
        check("ovf_set", o_overflow, 1'b1);
        strobe(2'd3, 24'h555555, 24'h666666, 1'b1, 1, 24'h0, 24'h0, 1'b1);
        check("ovf_set_wins", o_overflow, 1'b1);
        clear_flags();
        check("ovf_cleared", o_overflow, 1'b0);
        man_re = 1'b1;
        @(posedge clk); #1;
        man_re = 1'b0;
        check("pop_fill", o_in_fill, 5'd15);
        check("pop_head", o_data_to_eff, 16'h8000);
        check("pop_head_tag", o_eff_channel, 1'b1);

        // Misalignment: stray R word ahead of an aligned pair
        do_reset();
        man_dv = 1'b1; man_word = 16'h1111; man_tag = 1'b1;
        @(posedge clk); #1;
        man_word = 16'hAAAA; man_tag = 1'b0;
        @(posedge clk); #1;
        man_word = 16'h5555; man_tag = 1'b1;
        @(posedge clk); #1;
        man_dv = 1'b0;
        check("mis_fill", o_out_fill, 5'd3);
        strobe(2'd0, 24'h010203, 24'h040506, 1'b0, 0, 24'h0, 24'h0, 1'b0);
        check("mis_uf", o_underflow, 1'b1);
        check("mis_discard", o_out_fill, 5'd2);
        check("mis_hold", o_l_data, 24'h0);
        clear_flags();
        strobe(2'd0, 24'h070809, 24'h0A0B0C, 1'b1, 3, 24'hAAAA00, 24'h555500, 1'b0);
        check("mis_resync_fill", o_out_fill, 5'd0);
        check("mis_resync_uf", o_underflow, 1'b0);

        // Mono instance
        do_reset();
        mono_strobe(2'd0, 24'h345678);
        check("mono_in_fill", m_in_fill, 5'd1);
        check("mono_tag", m_ch, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("mono_uf", m_uf, 1'b1);
        check("mono_out_fill", m_out_fill, 5'd1);
        mono_strobe(2'd0, 24'hC0FFEE);
        check("mono_lat_early", m_valid, 1'b0);
        @(posedge clk); #1;
        check("mono_valid", m_valid, 1'b1);
        check("mono_l", m_l, 24'h345600);
        check("mono_r", m_r, 24'h345600);
        repeat (5) @(posedge clk);
        #1;
        mono_strobe(2'd1, 24'h7FFFFF);
        check("mono_byp_valid", m_valid, 1'b1);
        check("mono_byp_l", m_l, 24'h7FFFFF);
        check("mono_byp_r", m_r, 24'h7FFFFF);
        repeat (5) @(posedge clk);
        #1;

        check("sb_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/effect_stream_ctrl.md
Name: effect_stream_ctrl

Overview:
Single-clock, parametrised successor to the audio effect controller. It frames stereo (or mono) codec samples into a channel-tagged FIFO stream for the effect chain, and collects the processed stream in a second FIFO. On each audio sample strobe it rebuilds aligned L/R output words. It adds bypass/mute modes, frame-atomic overflow handling, underflow hold, channel resync and fill-level reporting.

Parameters:
d_width, 24, codec sample width
memory_d_width, 16, stream word width; uses the top memory_d_width bits of each sample
address_width, 4, FIFO address width
ram_depth, 16, FIFO depth; must equal 2**address_width
channels, 2, 1 = mono (L only), 2 = stereo

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
i_sample_valid  in  1  one-cycle audio frame strobe; strobes are at least 4 cycles apart
i_l_data  in  d_width  signed left sample
i_r_data  in  d_width  signed right sample (ignored when channels=1)
i_mode  in  2  0 = effect, 1 = bypass, 2 = mute, 3 = mute
i_clear_flags  in  1  clears the sticky flags
o_l_data  out  d_width  signed left output
o_r_data  out  d_width  signed right output
o_out_valid  out  1  one-cycle pulse when o_l_data/o_r_data update
o_data_to_eff  out  memory_d_width  input FIFO head word (first-word fall-through)
o_eff_channel  out  1  channel tag of the head word (0 = L, 1 = R)
o_data_valid  out  1  input FIFO not empty
i_read_enable  in  1  pop the head word; ignored while empty
i_data_from_eff  in  memory_d_width  processed word
i_eff_channel  in  1  tag of the processed word
i_dv_from_eff  in  1  write strobe for the processed word
o_in_fill  out  address_width+1  input FIFO word count
o_out_fill  out  address_width+1  output FIFO word count
o_overflow  out  1  sticky: a frame or word was dropped
o_underflow  out  1  sticky: output frame unavailable or misaligned

Behaviour:
- Reset: both FIFOs empty. All outputs 0. Sequencers idle. Sticky flags 0. A reset mid-frame abandons any partial push or pop.
- Internal FIFOs are width memory_d_width+1 (word plus tag), synchronous, first-word fall-through, with counts 0..ram_depth.

Input framer:
- States IDLE, PUSH_L, PUSH_R.
- On i_sample_valid, latch both truncated samples.
- If free space >= channels, write L (tag 0) in the strobe cycle, then R (tag 1) in the next cycle when channels=2.
- Otherwise drop the whole frame and set o_overflow. A partial frame is never written.
- The framer runs in every mode.

Effect side:
- A pop occurs when i_read_enable=1 and the FIFO is not empty. The next head is visible on the following cycle.
- Output FIFO writes on i_dv_from_eff=1. If it is full, the word is dropped and o_overflow is set.
- Simultaneous push and pop on either FIFO: count unchanged, both operations take effect.

Output assembler:
- States IDLE, POP_L, POP_R, UPDATE.
- Mode is sampled at the strobe and a mid-frame mode change applies from the next strobe.
- Effect mode, on strobe:
  - If o_out_fill >= channels and the head tag = 0: pop L, then R (stereo), then update the outputs together in UPDATE and pulse o_out_valid. Latency is strobe + 3 cycles for stereo, + 2 for mono.
  - If o_out_fill < channels: hold the previous outputs, set o_underflow, no o_out_valid pulse.
  - If the head tag = 1 (misaligned): discard one word, set o_underflow, hold the outputs. Resync completes over later strobes.
- Bypass mode: outputs are the full-width latched inputs. Output FIFO frames are still popped and discarded so the chain stays drained. o_out_valid pulses at strobe + 1.
- Mute mode: outputs are 0, the output FIFO is drained as in bypass, and o_out_valid pulses.
- Width rule: the stream word occupies the MSBs of the output, with the low d_width-memory_d_width bits set to 0 (sign preserved).
- channels=1: o_r_data mirrors o_l_data.
- Flags: i_clear_flags clears both flags. If clear and a set event occur in the same cycle, set wins.

Test Plan:
- Reset, then check that all outputs are 0, o_data_valid=0 and fills are 0.
- Stereo effect-mode loopback: strobe with L=0x123456, R=0xFEDCBA. The bench echoes each word with its tag. At the next strobe + 3, expect o_l_data=0x123400, o_r_data=0xFEDC00, o_out_valid pulse, no flags set.
- Overflow: hold i_read_enable=0 for 9 strobes (16-deep FIFO). The 9th frame is dropped, o_in_fill=16 and o_overflow=1. Then i_clear_flags returns it to 0.
- Underflow: effect mode with an empty output FIFO. On strobe, outputs hold their previous values, o_underflow=1 and no o_out_valid.
- Misalignment: inject a tag-1 word first, then a correct L/R pair. The first strobe discards the word and sets o_underflow. A later strobe outputs the aligned pair.
- Bypass/mute/mono: bypass with L=0x7FFFFF gives o_l_data=0x7FFFFF at strobe + 1. Mute gives 0. With channels=1, only tag-0 words are pushed and o_r_data equals o_l_data.
